// File: rtl/generic_rom_rd_pkg.sv
// -----------------------------------------------------------------------------
// generic_rom_rd_pkg
// Shared constants and helpers for the generic_rom read controller.
//   GENERIC_ROM_RD_LATENCY : fixed read latency of generic_rom, in clock edges.
//   count_width()          : bits needed to hold an occupancy of 0..depth.
// -----------------------------------------------------------------------------
package generic_rom_rd_pkg;

    localparam int GENERIC_ROM_RD_LATENCY = 2;

    // One extra bit over the pointer width so that "depth" itself is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/generic_rom_rd_fifo.sv
// -----------------------------------------------------------------------------
// generic_rom_rd_fifo
// First-word-fall-through response FIFO for the generic_rom read controller.
// Ports:
//   i_clk, i_rstn   clock, asynchronous active-low reset
//   i_push          write i_push_data this edge
//   i_push_data     word to store
//   i_pop           consume the head entry this edge (ignored when empty)
//   o_head_data     current head entry (valid when !o_empty)
//   o_empty         FIFO holds no entries
//   o_count         number of entries held, 0..DEPTH
// A push and a pop in the same cycle are both performed, including at full.
// -----------------------------------------------------------------------------
module generic_rom_rd_fifo
    import generic_rom_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic                              i_push,
    input  logic [DATA_WIDTH-1:0]             i_push_data,
    input  logic                              i_pop,
    output logic [DATA_WIDTH-1:0]             o_head_data,
    output logic                              o_empty,
    output logic [count_width(DEPTH)-1:0]     o_count
);

    localparam int CW = count_width(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // At full the write slot is the head slot, so it may only be reused when
    // the head leaves on the same edge.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // NOTE: the storage is cleared on reset because the head entry is visible
    // on o_head_data and must read as zero out of reset.
    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;

    // Upstream credits make a push into a full FIFO without a pop impossible.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
        !(i_push && w_full && !i_pop));

endmodule

// File: rtl/generic_rom_rd_ctrl.sv
// -----------------------------------------------------------------------------
// generic_rom_rd_ctrl
// Request/response front end for generic_rom. Accepts word-address reads on a
// valid/ready handshake, tracks the ROM's fixed non-stallable read latency and
// buffers returned words in a credit-protected FWFT response FIFO.
// Ports:
//   i_clk, i_rstn     clock (shared with generic_rom), async active-low reset
//   i_req_addr        requested word address
//   i_req_valid       request valid
//   o_req_ready       request accepted when valid && ready at posedge
//   o_rom_address     to generic_rom i_address (passthrough of i_req_addr)
//   i_rom_read_data   from generic_rom o_read_data
//   o_rsp_data        response word (FIFO head)
//   o_rsp_valid       response valid
//   i_rsp_ready       response consumed when valid && ready at posedge
//   o_busy            any request in flight or buffered
// -----------------------------------------------------------------------------
module generic_rom_rd_ctrl
    import generic_rom_rd_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    output logic [ADDRESS_WIDTH-1:0] o_rom_address,
    input  logic [DATA_WIDTH-1:0]    i_rom_read_data,
    output logic [DATA_WIDTH-1:0]    o_rsp_data,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic                     o_busy
);

    localparam int CW  = count_width(FIFO_DEPTH);
    localparam int LAT = GENERIC_ROM_RD_LATENCY;

    // r_pipe[0] is v1 (accepted one edge ago), r_pipe[LAT-1] is v2 (ROM data
    // for that request is on i_rom_read_data this cycle).
    logic [LAT-1:0] r_pipe;

    logic          w_accept;
    logic          w_pop;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [CW-1:0] w_occ;

    // The ROM samples the address every edge; only accepted edges enter r_pipe.
    assign o_rom_address = i_req_addr;

    assign w_accept = i_req_valid && o_req_ready;
    assign w_pop    = o_rsp_valid && i_rsp_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= {r_pipe[LAT-2:0], w_accept};
        end
    end

    // Credits: every in-flight request owns a FIFO slot, so a push can never
    // find the FIFO full. Built only from registers, so i_rsp_ready has no
    // combinational path to o_req_ready.
    // NOTE: w_occ is assigned before the loop so every path writes it and no
    // latch is inferred.
    always_comb begin
        w_occ = w_fifo_count;
        for (int i = 0; i < LAT; i++) begin
            w_occ = w_occ + CW'(r_pipe[i]);
        end
    end

    assign o_req_ready = (w_occ < CW'(FIFO_DEPTH));
    assign o_rsp_valid = !w_fifo_empty;
    assign o_busy      = (|r_pipe) || !w_fifo_empty;

    generic_rom_rd_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_push      (r_pipe[LAT-1]),
        .i_push_data (i_rom_read_data),
        .i_pop       (w_pop),
        .o_head_data (o_rsp_data),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

endmodule

// File: tb/tb_generic_rom_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_generic_rom_rd_ctrl
// Directed bench for generic_rom_rd_ctrl with a behavioural two-cycle ROM.
// -----------------------------------------------------------------------------
module tb_generic_rom_rd_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] req_addr;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] rom_address;
    logic [DW-1:0] rom_read_data;
    logic [DW-1:0] rsp_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          busy;

    always #5 clk = ~clk;

    generic_rom_rd_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_req_addr      (req_addr),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .o_rom_address   (rom_address),
        .i_rom_read_data (rom_read_data),
        .o_rsp_data      (rsp_data),
        .o_rsp_valid     (rsp_valid),
        .i_rsp_ready     (rsp_ready),
        .o_busy          (busy)
    );

    // Two-cycle ROM: address registered at E0, data registered at E1.
    logic [DW-1:0] rom [16];
    logic [AW-1:0] rom_a1;
    always @(posedge clk) begin
        rom_a1        <= rom_address;
        rom_read_data <= rom[rom_a1[3:0]];
    end

    // Response log, sampled on the falling edge ahead of the consuming posedge.
    int            cyc = 0;
    logic [DW-1:0] rsp_q[$];
    int            rsp_cyc_q[$];
    int            max_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (rsp_valid && rsp_ready) begin
                rsp_q.push_back(rsp_data);
                rsp_cyc_q.push_back(cyc);
            end
            if (int'(dut.u_fifo.o_count) > max_count) max_count = int'(dut.u_fifo.o_count);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   idx;
        logic acc;
        logic flag;

        rstn      = 1'b0;
        req_addr  = '0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 32'(i * 3);
        rom[5] = 32'hDEADBEEF;

        // ---- reset state ----
        tick();
        tick();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data",  64'(rsp_data),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        rstn = 1'b1;
        tick();

        // ---- single read of addr 5 ----
        rsp_ready = 1'b1;
        req_addr  = 32'd5;
        req_valid = 1'b1;
        check("rom_addr_passthru", 64'(rom_address), 64'd5);
        tick();                                   // E0: accept
        req_valid = 1'b0;
        check("single_busy_e0",  64'(busy),      64'd1);
        check("single_valid_e0", 64'(rsp_valid), 64'd0);
        tick();                                   // E1
        check("single_valid_e1", 64'(rsp_valid), 64'd0);
        tick();                                   // E2: pushed
        check("single_valid_e2", 64'(rsp_valid), 64'd1);
        check("single_data_e2",  64'(rsp_data),  64'hDEADBEEF);
        tick();                                   // E3: popped
        check("single_valid_e3", 64'(rsp_valid), 64'd0);
        check("single_busy_e3",  64'(busy),      64'd0);

        // ---- streaming 16 back-to-back ----
        rom[5] = 32'd15;
        rsp_q.delete();
        rsp_cyc_q.delete();
        flag = 1'b0;
        for (int i = 0; i < 16; i++) begin
            req_addr  = 32'(i);
            req_valid = 1'b1;
            if (!req_ready) flag = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        repeat (6) tick();
        check("stream_ready_drop", 64'(flag), 64'd0);
        check("stream_count", 64'(rsp_q.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < rsp_q.size()) check($sformatf("stream_data_%0d", i), 64'(rsp_q[i]), 64'(i * 3));
        end
        if (rsp_cyc_q.size() == 16)
            check("stream_consecutive", 64'(rsp_cyc_q[15] - rsp_cyc_q[0]), 64'd15);
        check("stream_busy_end", 64'(busy), 64'd0);

        // ---- backpressure: 6 offered, 4 accepted ----
        rsp_q.delete();
        rsp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10 && idx < 6; c++) begin
            req_addr  = 32'(idx);
            req_valid = 1'b1;
            acc = req_ready;
            tick();
            if (acc) idx++;
        end
        check("bp_accepted",   64'(idx),       64'd4);
        check("bp_req_ready",  64'(req_ready), 64'd0);
        check("bp_rsp_valid",  64'(rsp_valid), 64'd1);
        check("bp_head_data",  64'(rsp_data),  64'd0);
        check("bp_fifo_count", 64'(dut.u_fifo.o_count), 64'd4);

        // ---- full FIFO: single pop pulse frees one credit ----
        rsp_ready = 1'b1;
        tick();                                   // pop addr0 data
        rsp_ready = 1'b0;
        check("full_ready_after_pop", 64'(req_ready), 64'd1);
        check("full_count_after_pop", 64'(dut.u_fifo.o_count), 64'd3);
        check("full_head_after_pop",  64'(rsp_data), 64'd3);
        tick();                                   // addr 4 accepted
        check("full_ready_after_acc", 64'(req_ready), 64'd0);
        req_addr = 32'd5;
        rsp_ready = 1'b1;
        flag = 1'b0;
        for (int c = 0; c < 20 && !flag; c++) begin
            acc = req_ready;
            tick();
            if (acc) flag = 1'b1;
        end
        check("bp_last_accepted", 64'(flag), 64'd1);
        req_valid = 1'b0;
        repeat (8) tick();
        check("bp_rsp_count", 64'(rsp_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < rsp_q.size()) check($sformatf("bp_data_%0d", i), 64'(rsp_q[i]), 64'(i * 3));
        end
        check("max_fifo_count", 64'(max_count), 64'd4);
        check("bp_busy_end", 64'(busy), 64'd0);

        // ---- reset mid-operation ----
        rsp_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            req_addr  = 32'(i);
            req_valid = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        tick();
        rstn = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_busy",      64'(busy),      64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        check("midrst_rsp_data",  64'(rsp_data),  64'd0);
        tick();
        rstn = 1'b1;
        rsp_ready = 1'b1;
        rsp_q.delete();
        flag = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) flag = 1'b1;
        end
        check("midrst_no_stale",  64'(flag), 64'd0);
        check("midrst_rsp_count", 64'(rsp_q.size()), 64'd0);

        req_addr  = 32'd7;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        check("post_rst_count", 64'(rsp_q.size()), 64'd1);
        if (rsp_q.size() > 0) check("post_rst_data", 64'(rsp_q[0]), 64'd21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
